// File: rtl/bip_debug_sequencer_if.sv
// UART FIFO and BIP core signals seen by the debug sequencer.
// master = sequencer side, slave = the UART/BIP side that drives status and data.
interface bip_debug_sequencer_if #(
  parameter int AB = 11,
  parameter int DB = 16
);
  logic          rx_empty;
  logic [7:0]    r_data;
  logic          rd_uart;
  logic          tx_full;
  logic [7:0]    w_data;
  logic          wr_uart;
  logic [4:0]    opcode;
  logic [AB-1:0] pc;
  logic [DB-1:0] acc;
  logic          start_bip;
  logic          busy;

  modport master (
    input  rx_empty, r_data, tx_full, opcode, pc, acc,
    output rd_uart, w_data, wr_uart, start_bip, busy
  );

  modport slave (
    output rx_empty, r_data, tx_full, opcode, pc, acc,
    input  rd_uart, w_data, wr_uart, start_bip, busy
  );
endinterface

// File: rtl/bip_debug_sequencer.sv
// Debug sequencer: start command -> run the BIP until HALT -> stream an acc/pc/cycle result frame.
// Define BIP_DBG_CHECKSUM_EN to append an XOR checksum byte to the frame.
module bip_debug_sequencer #(
  parameter int         AB        = 11,
  parameter int         DB        = 16,
  parameter logic [7:0] START_CMD = 8'h73
) (
  input logic                   clk,
  input logic                   reset,
  bip_debug_sequencer_if.master bus
);

`ifdef BIP_DBG_CHECKSUM_EN
  localparam int FRAME_LEN = 8;
`else
  localparam int FRAME_LEN = 7;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, POP, RUN, SEND} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cmd_reg, cmd_next;
  logic [15:0] cyc_reg, cyc_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] pc_reg, pc_next;
  logic [2:0]  idx_reg, idx_next;
  logic        start_bip_reg;

  logic [15:0] cyc_inc;
  logic [7:0]  frame_byte;
  logic        rd_uart_int;
  logic        wr_uart_int;
  logic [7:0]  w_data_int;

  // Cycle counter saturates so very long runs report 16'hFFFF instead of wrapping.
  assign cyc_inc = (cyc_reg == 16'hFFFF) ? cyc_reg : cyc_reg + 16'd1;

`ifdef BIP_DBG_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = acc_reg[15:8] ^ acc_reg[7:0] ^ pc_reg[15:8] ^ pc_reg[7:0]
                  ^ cnt_reg[15:8] ^ cnt_reg[7:0];
`endif

  always_comb begin
    frame_byte = 8'h00;
    case (idx_reg)
      3'd0:    frame_byte = 8'hA5;
      3'd1:    frame_byte = acc_reg[15:8];
      3'd2:    frame_byte = acc_reg[7:0];
      3'd3:    frame_byte = pc_reg[15:8];
      3'd4:    frame_byte = pc_reg[7:0];
      3'd5:    frame_byte = cnt_reg[15:8];
      3'd6:    frame_byte = cnt_reg[7:0];
`ifdef BIP_DBG_CHECKSUM_EN
      3'd7:    frame_byte = checksum;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cmd_next    = cmd_reg;
    cyc_next    = cyc_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    pc_next     = pc_reg;
    idx_next    = idx_reg;
    rd_uart_int = 1'b0;
    wr_uart_int = 1'b0;
    w_data_int  = 8'h00;

    case (state_reg)
      IDLE: begin
        if (!bus.rx_empty) begin
          cmd_next   = bus.r_data;
          state_next = POP;
        end
      end
      POP: begin
        rd_uart_int = 1'b1;
        if (cmd_reg == START_CMD) begin
          cyc_next   = 16'd0;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        cyc_next = cyc_inc;
        // The HALT edge itself counts as an executed cycle.
        if (bus.opcode == 5'b00000) begin
          acc_next   = 16'(bus.acc);
          pc_next    = 16'(bus.pc);
          cnt_next   = cyc_inc;
          idx_next   = 3'd0;
          state_next = SEND;
        end
      end
      SEND: begin
        w_data_int = frame_byte;
        if (!bus.tx_full) begin
          wr_uart_int = 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cmd_reg       <= 8'h00;
      cyc_reg       <= 16'h0000;
      cnt_reg       <= 16'h0000;
      acc_reg       <= 16'h0000;
      pc_reg        <= 16'h0000;
      idx_reg       <= 3'd0;
      start_bip_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_reg       <= cmd_next;
      cyc_reg       <= cyc_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      pc_reg        <= pc_next;
      idx_reg       <= idx_next;
      // Registered from the next state so the BIP stops right after the HALT edge.
      start_bip_reg <= (state_next == RUN);
    end
  end

  assign bus.rd_uart   = rd_uart_int;
  assign bus.wr_uart   = wr_uart_int;
  assign bus.w_data    = w_data_int;
  assign bus.start_bip = start_bip_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_bip_debug_sequencer.sv
// Self-checking bench for bip_debug_sequencer: FIFO/BIP models, frame reference built from
// the values present at the HALT cycle, randomized run lengths, stalls and RX noise.
module tb_bip_debug_sequencer;
  localparam int         AB        = 11;
  localparam int         DB        = 16;
  localparam logic [7:0] START_CMD = 8'h73;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bip_debug_sequencer_if #(.AB(AB), .DB(DB)) bus ();

  bip_debug_sequencer #(.AB(AB), .DB(DB), .START_CMD(START_CMD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [7:0] rx_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];

  bit pop_pending = 0;
  int cycle = 0;
  int rd_cnt = 0;
  int halt_after = 0;
  int run_edges = 0;
  int start_high = 0;
  int stall_byte = -1;
  int stall_len = 0;
  int stall_cnt = 0;
  bit rand_full = 0;
  bit rx_noise = 0;
  bit fixed_vals = 0;
  bit exp_valid = 0;
  int first_ne = -1;
  int first_rd = -1;
  int first_start = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference frame: header, acc, pc, saturated cycle count, optional XOR of bytes 1..6.
  task automatic build_frame(input logic [15:0] a, input logic [15:0] p, input int cycles);
    logic [15:0] c;
    logic [7:0]  x;
    c = (cycles > 65535) ? 16'hFFFF : 16'(cycles);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
`ifdef BIP_DBG_CHECKSUM_EN
    x = 8'h00;
    for (int i = 1; i < 7; i++) x = x ^ exp_q[i];
    exp_q.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  // One clock: drive inputs after the falling edge, sample combinational outputs 1 time unit later.
  task automatic step();
    logic sb, bz, rdv, sending;
    logic [4:0] opc;
    @(negedge clk);
    if (pop_pending) begin
      if (rx_q.size() > 0) rx_q.delete(0);
      pop_pending = 0;
    end
    sb  = bus.start_bip;
    bz  = bus.busy;
    rdv = bus.rd_uart;

    if (rx_noise && bz && !rdv) begin
      bus.rx_empty = 1'($urandom_range(0, 1));
      bus.r_data   = 8'($urandom);
    end else if (rx_q.size() == 0) begin
      bus.rx_empty = 1'b1;
      bus.r_data   = 8'($urandom);
    end else begin
      bus.rx_empty = 1'b0;
      bus.r_data   = rx_q[0];
      if (first_ne < 0 && !bz && reset) first_ne = cycle;
    end

    if (fixed_vals) begin
      bus.acc = 16'h1234;
      bus.pc  = 11'h00A;
    end else begin
      bus.acc = 16'($urandom);
      bus.pc  = 11'($urandom);
    end
    if (sb) begin
      if (run_edges == halt_after) begin
        opc = 5'd0;
        build_frame(16'(bus.acc), 16'(bus.pc), halt_after + 1);
        exp_valid = 1;
      end else begin
        opc = 5'($urandom_range(1, 31));
      end
      run_edges++;
      start_high++;
      if (first_start < 0) first_start = cycle;
    end else begin
      opc = 5'($urandom);
    end
    bus.opcode = opc;

    sending = exp_valid && !sb && (cap_q.size() < exp_q.size());
    if (sending && cap_q.size() == stall_byte && stall_cnt < stall_len) begin
      bus.tx_full = 1'b1;
      stall_cnt++;
    end else if (sending && rand_full) begin
      bus.tx_full = ($urandom_range(0, 3) == 0);
    end else begin
      bus.tx_full = 1'b0;
    end

    #1;
    if (sending && reset) begin
      check("w_data", bus.w_data, exp_q[cap_q.size()]);
      check("wr_uart", bus.wr_uart, !bus.tx_full);
    end
    if (bus.wr_uart) cap_q.push_back(bus.w_data);
    if (bus.rd_uart) begin
      pop_pending = 1;
      rd_cnt++;
      if (first_rd < 0) first_rd = cycle;
    end
    cycle++;
  endtask

  task automatic arm_run(input int ha, input int sbyte, input int slen, input bit rf,
                         input bit noise, input bit fixed);
    halt_after  = ha;
    run_edges   = 0;
    start_high  = 0;
    stall_byte  = sbyte;
    stall_len   = slen;
    stall_cnt   = 0;
    rand_full   = rf;
    rx_noise    = noise;
    fixed_vals  = fixed;
    exp_valid   = 0;
    first_ne    = -1;
    first_rd    = -1;
    first_start = -1;
    cap_q.delete();
    rx_q.push_back(START_CMD);
  endtask

  task automatic run_and_check(input string tag, input int ha, input int sbyte, input int slen,
                               input bit rf, input bit noise, input bit fixed);
    int budget;
    arm_run(ha, sbyte, slen, rf, noise, fixed);
    budget = ha + 300;
    while (!(exp_valid && cap_q.size() >= exp_q.size()) && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_finished"}, budget > 0, 1);
    step();
    step();
    check({tag, "_busy_after"}, bus.busy, 1'b0);
    check({tag, "_start_cycles"}, start_high, ha + 1);
    check({tag, "_rd_latency"}, first_rd - first_ne, 1);
    check({tag, "_start_latency"}, first_start - first_ne, 2);
    check({tag, "_frame_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
    $display("run %s: halt_after=%0d start_cycles=%0d frame=%p", tag, ha, start_high, cap_q);
  endtask

  initial begin
    int rd_before;
    int n_after;
    int budget;
    logic [7:0] junk;

    bus.rx_empty = 1'b1;
    bus.r_data   = 8'h00;
    bus.tx_full  = 1'b0;
    bus.opcode   = 5'd1;
    bus.pc       = '0;
    bus.acc      = '0;

    // Reset held for three edges
    reset = 1'b0;
    repeat (3) step();
    check("rst_start_bip", bus.start_bip, 1'b0);
    check("rst_rd_uart", bus.rd_uart, 1'b0);
    check("rst_wr_uart", bus.wr_uart, 1'b0);
    check("rst_w_data", bus.w_data, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("idle_busy", bus.busy, 1'b0);
      check("idle_rd", bus.rd_uart, 1'b0);
    end

    // Non-start bytes are popped and dropped
    for (int k = 0; k < 2; k++) begin
      junk = 8'h41;
      if (k == 1) begin
        junk = 8'($urandom);
        while (junk == START_CMD) junk = 8'($urandom);
      end
      rd_before  = rd_cnt;
      start_high = 0;
      rx_q.push_back(junk);
      repeat (6) step();
      check("discard_pops", rd_cnt - rd_before, 1);
      check("discard_no_start", start_high, 0);
      check("discard_busy", bus.busy, 1'b0);
      $display("discard byte %02h: pops=%0d", junk, rd_cnt - rd_before);
    end

    // Directed run: 9 ordinary instructions then HALT, fixed acc/pc
    run_and_check("basic", 9, -1, 0, 0, 0, 1);
    // Same run with a 5-cycle transmit stall before byte 2
    run_and_check("stall", 9, 2, 5, 0, 0, 1);
    // HALT on the very first run edge
    run_and_check("halt_first", 0, -1, 0, 0, 0, 0);
    // Randomized run lengths, transmit back-pressure and RX activity during RUN/SEND
    for (int r = 0; r < 4; r++)
      run_and_check($sformatf("rand%0d", r), $urandom_range(1, 60), -1, 0, 1, 1, 0);

    // Reset during SEND after three bytes
    arm_run(4, -1, 0, 0, 0, 0);
    budget = 300;
    while (cap_q.size() < 3 && budget > 0) begin
      step();
      budget--;
    end
    check("abort_reached", budget > 0, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_valid = 0;
    n_after = cap_q.size();
    step();
    check("abort_busy", bus.busy, 1'b0);
    check("abort_wr_uart", bus.wr_uart, 1'b0);
    check("abort_start_bip", bus.start_bip, 1'b0);
    repeat (10) step();
    check("abort_no_more_bytes", cap_q.size(), n_after);
    $display("abort: bytes written before reset=%0d", n_after);
    run_and_check("after_abort", 5, -1, 0, 0, 0, 0);

    // Long run: cycle count saturates
    run_and_check("saturate", 70000, -1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
